// File: rtl/vga_sync_generator.sv
// ---------------------------------------------------------------------------
// vga_sync_generator
//
// VGA timing stage clocked by the 25 MHz pixel clock from the 50->25 MHz
// divider. Produces hsync/vsync, blanking, a frame-start strobe and the pixel
// coordinates consumed by the pixel-colour logic. Default timing is
// 640x480 @ 60 Hz (800x525 total).
//
// Ports:
//   clk          in   1   pixel clock
//   reset        in   1   asynchronous, active-low reset
//   hsync        out  1   horizontal sync, level SYNC_POL when asserted
//   vsync        out  1   vertical sync, level SYNC_POL when asserted
//   blank_n      out  1   1 = visible pixel, 0 = blanking
//   sync_n       out  1   constant 0 (DAC composite sync unused)
//   frame_start  out  1   one-cycle strobe at pixel (0,0)
//   x            out  10  horizontal counter, 0..H_TOTAL-1
//   y            out  10  vertical counter, 0..V_TOTAL-1
//   r, g, b      out  8   colour-bar test pattern (only with VGA_TESTPATTERN_EN)
//
// Optional feature macro: VGA_TESTPATTERN_EN adds the r/g/b test-pattern
// outputs. Timing outputs are identical with or without it.
//
// Every output is a flop loaded from the next-count values, so all outputs
// describe the same pixel as x/y in the same cycle.
// ---------------------------------------------------------------------------
module vga_sync_generator #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic       sync_n,
  output logic       frame_start,
  output logic [9:0] x,
  output logic [9:0] y
`ifdef VGA_TESTPATTERN_EN
  ,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_blank_n;
  logic       r_frame_start;

  logic       w_h_wrap;
  logic [9:0] w_h_next;
  logic [9:0] w_v_next;
  logic       w_hs_act;
  logic       w_vs_act;
  logic       w_blank_n_next;
  logic       w_frame_start_next;

  assign w_h_wrap = (r_h_cnt == H_LAST);
  assign w_h_next = w_h_wrap ? 10'd0 : r_h_cnt + 10'd1;
  // Vertical counter only moves on a horizontal wrap.
  assign w_v_next = !w_h_wrap          ? r_v_cnt :
                    (r_v_cnt == V_LAST) ? 10'd0   : r_v_cnt + 10'd1;

  assign w_hs_act           = (w_h_next >= HS_START) && (w_h_next < HS_END);
  assign w_vs_act           = (w_v_next >= VS_START) && (w_v_next < VS_END);
  assign w_blank_n_next     = (w_h_next < H_ACT) && (w_v_next < V_ACT);
  assign w_frame_start_next = (w_h_next == 10'd0) && (w_v_next == 10'd0);

  // Reset parks the counters on the last pixel of the frame so the first
  // clock after release lands on (0,0) with frame_start asserted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_h_cnt       <= H_LAST;
      r_v_cnt       <= V_LAST;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_blank_n     <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_h_cnt       <= w_h_next;
      r_v_cnt       <= w_v_next;
      r_hsync       <= w_hs_act ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      r_blank_n     <= w_blank_n_next;
      r_frame_start <= w_frame_start_next;
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign blank_n     = r_blank_n;
  assign frame_start = r_frame_start;
  assign sync_n      = 1'b0;
  assign x           = r_h_cnt;
  assign y           = r_v_cnt;

`ifdef VGA_TESTPATTERN_EN
  // Eight vertical bars of H_ACTIVE/8 pixels:
  // white, yellow, cyan, green, magenta, red, blue, black.
  // With the bar index b[2:0]: red is on when b[1]==0, green when b[2]==0,
  // blue when b[0]==0.
  localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);

  logic [7:0] r_r;
  logic [7:0] r_g;
  logic [7:0] r_b;
  logic [9:0] w_bar_q;
  logic [2:0] w_bar;

  assign w_bar_q = w_h_next / BAR_W;
  // Clamp covers the few leftover pixels when H_ACTIVE is not a multiple of 8.
  assign w_bar   = (w_bar_q > 10'd7) ? 3'd7 : w_bar_q[2:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_r <= 8'h00;
      r_g <= 8'h00;
      r_b <= 8'h00;
    end else if (w_blank_n_next) begin
      r_r <= {8{~w_bar[1]}};
      r_g <= {8{~w_bar[2]}};
      r_b <= {8{~w_bar[0]}};
    end else begin
      r_r <= 8'h00;
      r_g <= 8'h00;
      r_b <= 8'h00;
    end
  end

  assign r = r_r;
  assign g = r_g;
  assign b = r_b;
`endif

endmodule
